// File: rtl/fir_out_buffer.sv
// Output stage for the 4-tap FIR: scales 18-bit results to 16 bits and buffers them in a FWFT FIFO.
// Define FIR_OUT_ROUND_EN for round-half-up with saturation; otherwise the result is truncated.
module fir_out_buffer #(
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [17:0]                data_in,
  input  logic                       data_valid,
  output logic [15:0]                m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       almost_full,
  output logic                       overflow,
  output logic [7:0]                 drop_count,
  input  logic                       clear_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   scaled_q, scaled_d;
  logic          s1_valid_q, s1_valid_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          m_valid_q, m_valid_d;
  logic          almost_full_q, almost_full_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_count_q, drop_count_d;

  logic [15:0]   mem [DEPTH];
  logic [15:0]   scale_result;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;

`ifdef FIR_OUT_ROUND_EN
  logic [18:0] round_sum;
  logic [16:0] round_shifted;
  always_comb begin
    round_sum     = {1'b0, data_in} + 19'd2;
    round_shifted = round_sum[18:2];
    // Only 262142/262143 round past 16 bits; clamp those to full scale.
    scale_result  = round_shifted[16] ? 16'hFFFF : round_shifted[15:0];
  end
`else
  logic unused_lsbs;
  assign unused_lsbs  = ^data_in[1:0];
  assign scale_result = data_in[17:2];
`endif

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    pop     = m_valid_q & m_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    push_ok = s1_valid_q & (~full | pop);
    drop    = s1_valid_q & full & ~pop;

    s1_valid_d = data_valid;
    scaled_d   = data_valid ? scale_result : scaled_q;

    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CW'(1);
    end

    m_valid_d     = (count_d != '0);
    almost_full_d = (count_d >= CW'(AFULL_LVL));

    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (drop) begin
      overflow_d   = 1'b1;
      drop_count_d = clear_ovf ? 8'd1
                   : (drop_count_q == 8'hFF) ? 8'hFF : drop_count_q + 8'd1;
    end else if (clear_ovf) begin
      overflow_d   = 1'b0;
      drop_count_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scaled_q      <= '0;
      s1_valid_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      m_valid_q     <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      scaled_q      <= scaled_d;
      s1_valid_q    <= s1_valid_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      m_valid_q     <= m_valid_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
      drop_count_q  <= drop_count_d;
    end
  end

  // Storage carries no reset; stale entries are masked by the occupancy count.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr_q] <= scaled_q;
    end
  end

  assign m_data      = m_valid_q ? mem[rd_ptr_q] : 16'd0;
  assign m_valid     = m_valid_q;
  assign fill_level  = count_q;
  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_fir_out_buffer.sv
// Directed self-checking bench for fir_out_buffer (DEPTH=8, AFULL_LVL=6).
module tb_fir_out_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] data_in;
  logic        data_valid;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  fill_level;
  logic        almost_full;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        clear_ovf;

  int n_compared   = 0;
  int n_mismatched = 0;

  fir_out_buffer #(.DEPTH(8), .AFULL_LVL(6)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fill_level(fill_level), .almost_full(almost_full),
    .overflow(overflow), .drop_count(drop_count), .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance one edge, then let outputs settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag, input int unsigned exp);
    check_val({tag, ".valid"}, m_valid, 1);
    check_val({tag, ".data"}, m_data, exp);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    int unsigned exp_r [3];
    rst = 1'b1; data_in = '0; data_valid = 1'b0; m_ready = 1'b0; clear_ovf = 1'b0;
    #1;

    // Reset and first-sample latency
    tick(); tick();
    check_val("rst.m_valid", m_valid, 0);
    check_val("rst.m_data", m_data, 0);
    check_val("rst.fill", fill_level, 0);
    check_val("rst.afull", almost_full, 0);
    check_val("rst.ovf", overflow, 0);
    check_val("rst.drops", drop_count, 0);
    rst = 1'b0;
    data_in = 18'd400; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check_val("lat.edgeN.m_valid", m_valid, 0);
    tick();
    check_val("lat.edgeN1.fill", fill_level, 1);
    pop_check("lat", 100);
    check_val("lat.empty", m_valid, 0);

    // Scaling
`ifdef FIR_OUT_ROUND_EN
    exp_r[0] = 1; exp_r[1] = 2; exp_r[2] = 65535;
`else
    exp_r[0] = 1; exp_r[1] = 1; exp_r[2] = 65535;
`endif
    data_valid = 1'b1;
    data_in = 18'd5;      tick();
    data_in = 18'd6;      tick();
    data_in = 18'd262143; tick();
    data_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) pop_check($sformatf("scale%0d", i), exp_r[i]);

    // Fill and overflow: 10 samples into 8 slots
    for (int t = 1; t <= 10; t++) begin
      data_in = 18'(4 * t); data_valid = 1'b1;
      tick();
      if (t == 6) check_val("fill.t6.afull", almost_full, 0);
      if (t == 7) begin
        check_val("fill.t7.level", fill_level, 6);
        check_val("fill.t7.afull", almost_full, 1);
      end
    end
    data_valid = 1'b0;
    tick();
    check_val("fill.level", fill_level, 8);
    check_val("fill.ovf", overflow, 1);
    check_val("fill.drops", drop_count, 2);
    for (int k = 1; k <= 8; k++) pop_check($sformatf("drain%0d", k), k);
    check_val("drain.empty", m_valid, 0);
    check_val("drain.afull", almost_full, 0);

    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    check_val("clr.ovf", overflow, 0);
    check_val("clr.drops", drop_count, 0);

    // Full FIFO with simultaneous pop and push
    for (int k = 1; k <= 8; k++) begin
      data_in = 18'(4 * k); data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    tick();
    check_val("fp.full", fill_level, 8);
    data_in = 18'd36; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check_val("fp.level", fill_level, 8);
    check_val("fp.drops", drop_count, 0);
    check_val("fp.ovf", overflow, 0);
    check_val("fp.head", m_data, 2);

    // Three drops, then a fourth colliding with clear_ovf
    data_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_in = 18'(400 + 4 * k);
      tick();
    end
    check_val("col.pre.drops", drop_count, 3);
    data_valid = 1'b0; clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check_val("col.ovf", overflow, 1);
    check_val("col.drops", drop_count, 1);
    check_val("col.hold", m_data, 2);
    for (int k = 2; k <= 9; k++) pop_check($sformatf("order%0d", k), k);
    check_val("order.empty", m_valid, 0);

    // Reset mid-stream
    data_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      data_in = 18'(40 * k);
      tick();
    end
    data_valid = 1'b0;
    tick();
    check_val("mid.level", fill_level, 5);
    rst = 1'b1; tick(); rst = 1'b0;
    check_val("mid.m_valid", m_valid, 0);
    check_val("mid.fill", fill_level, 0);
    check_val("mid.ovf", overflow, 0);
    data_in = 18'd800; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check_val("mid.lat1", m_valid, 0);
    tick();
    pop_check("mid.lat2", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
